// File: rtl/mux81_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and its 8:1 mux.
// The arbiter context (FSM state plus rotation pointer) is kept in one packed
// struct so checkers can bind to a single register.
package mux81_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e        state;
        logic [SEL_W-1:0]  ptr;
    } arb_ctx_t;

endpackage

// File: rtl/mux81_bh.sv
// Behavioural 8:1 single-bit multiplexer: o_y = i_data[i_sel].
module mux81_bh
    import mux81_pkg::*;
(
    input  logic [N_REQ-1:0] i_data,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_y
);

    // Plain indexed select; no registers.
    always_comb begin
        o_y = i_data[i_sel];
    end

endmodule

// File: rtl/mux81_rr_arb.sv
// Round-robin arbiter for 8 requesters sharing one 8:1 mux.
// Optional feature macro: MUX81_ARB_TIMEOUT_EN -- when defined, a grant held
// for TIMEOUT_CYCLES consecutive cycles is forcibly released and the timeout
// output pulses for one cycle. When undefined there is no hold counter and
// timeout is tied low; the port list is identical in both builds.
//
// Handshake: req[k] is a level request. A grant is given one cycle after the
// arbiter sees any request while idle, and is held until the owner drops its
// request (or is forced off). Every release is followed by one idle cycle
// before the next grant, so gnt is never handed over back-to-back.
module mux81_rr_arb
    import mux81_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] i,
    output logic [7:0] gnt,
    output logic [2:0] s,
    output logic       busy,
    output logic       y,
    output logic       timeout
);

    arb_ctx_t         r_ctx;
    arb_ctx_t         w_ctx_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [SEL_W-1:0] r_s;
    logic [SEL_W-1:0] w_s_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [SEL_W-1:0] w_pick;
    logic             w_release;
    logic             w_force;
    logic             w_mux_y;

    // Rotating priority: first requester found scanning ptr, ptr+1, ... mod 8.
    // Scanning from the farthest offset down lets the nearest one win last.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req_v,
        input logic [SEL_W-1:0] ptr_v
    );
        logic [SEL_W-1:0] idx;
        rr_pick = ptr_v;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = ptr_v + SEL_W'(off);
            if (req_v[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign w_pick    = rr_pick(req, r_ctx.ptr);
    assign w_release = (r_ctx.state == GRANT) && !req[r_s];

`ifdef MUX81_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Counter holds the number of cycles the current grant has been visible.
    assign w_force = (r_ctx.state == GRANT) && req[r_s] &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Hold counter and one-cycle timeout pulse, aligned with the idle cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_ctx_nxt.state == GRANT) begin
                r_cnt <= (r_ctx.state == GRANT) ? r_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
    assign w_force      = 1'b0;
    assign timeout      = 1'b0;
`endif

    // State register plus registered grant outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctx.state <= IDLE;
            r_ctx.ptr   <= '0;
            r_gnt       <= '0;
            r_s         <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ctx  <= w_ctx_nxt;
            r_gnt  <= w_gnt_nxt;
            r_s    <= w_s_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Next state: grant on any request, release on owner drop or forced timeout.
    always_comb begin
        w_ctx_nxt = r_ctx;
        case (r_ctx.state)
            IDLE: begin
                if (|req) begin
                    w_ctx_nxt.state = GRANT;
                end
            end
            GRANT: begin
                if (w_release || w_force) begin
                    w_ctx_nxt.state = IDLE;
                    w_ctx_nxt.ptr   = r_s + SEL_W'(1);
                end
            end
        endcase
    end

    // Next grant outputs; s is held whenever no grant is active.
    always_comb begin
        w_gnt_nxt  = r_gnt;
        w_s_nxt    = r_s;
        w_busy_nxt = r_busy;
        case (r_ctx.state)
            IDLE: begin
                if (|req) begin
                    w_gnt_nxt  = N_REQ'(1) << w_pick;
                    w_s_nxt    = w_pick;
                    w_busy_nxt = 1'b1;
                end else begin
                    w_gnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_release || w_force) begin
                    w_gnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                end
            end
        endcase
    end

    mux81_bh u_mux (
        .i_data (i),
        .i_sel  (r_s),
        .o_y    (w_mux_y)
    );

    assign gnt  = r_gnt;
    assign s    = r_s;
    assign busy = r_busy;
    assign y    = w_mux_y & r_busy;

endmodule

// File: tb/tb_mux81_rr_arb.sv
// Bench for mux81_rr_arb: directed vector table, timeout sequence, then a
// randomized run against a behavioural model with a grant-order scoreboard.
module tb_mux81_rr_arb;

    localparam int TC = 4;
`ifdef MUX81_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       y;
    logic       timeout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux81_rr_arb #(.TIMEOUT_CYCLES(TC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .i       (i),
        .gnt     (gnt),
        .s       (s),
        .busy    (busy),
        .y       (y),
        .timeout (timeout)
    );

    // ---------------- counters / checker ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    int         m_owner = -1;   // -1 means nobody holds the grant
    int         m_ptr   = 0;
    int         m_hold  = 0;
    bit         m_to    = 1'b0;
    logic [2:0] m_s     = 3'd0;
    bit         sb_on   = 1'b0;
    logic [2:0] exp_q[$];

    task automatic model_step();
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
            m_s     = 3'd0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (req != 8'h00) begin
                for (int j = 0; j < 8; j++) begin
                    if (req[(m_ptr + j) % 8]) begin
                        m_owner = (m_ptr + j) % 8;
                        break;
                    end
                end
                m_s    = 3'(m_owner);
                m_hold = 1;
                if (sb_on) exp_q.push_back(m_s);
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 1'b0;
        end else if (TO_EN && m_hold == TC) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_hold++;
            m_to = 1'b0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] ii);
        rst_n = r;
        req   = rq;
        i     = ii;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] i;
        logic [7:0] gnt;
        logic [2:0] s;
        logic       busy;
        logic       y;
        logic       to;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] ii,
                       input logic [7:0] g, input logic [2:0] ss,
                       input logic b, input logic yy, input logic tt);
        vec_t v;
        v.rst_n = r;  v.req = rq; v.i = ii;
        v.gnt = g;    v.s = ss;   v.busy = b; v.y = yy; v.to = tt;
        vt.push_back(v);
    endtask

    logic [7:0] pat;
    logic [7:0] one;
    logic [7:0] f_gnt[12];
    logic       f_to[12];
    logic       prev_busy;

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        i     = 8'h00;
        pat   = 8'hAA;

        // A: single request, release, pointer advance to 1
        add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h01, 8'h01, 8'h01, 3'd0, 1, 1, 0);
        add(1, 8'h00, 8'h01, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h03, 8'h00, 8'h02, 3'd1, 1, 0, 0);
        add(1, 8'h00, 8'h00, 8'h00, 3'd1, 0, 0, 0);
        // B: all requesting, each owner drops after 2 cycles -> 0..7,0
        add(0, 8'hFF, 8'hAA, 8'h00, 3'd0, 0, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            one = 8'h01 << (k % 8);
            add(1, 8'hFF, 8'hAA, one, 3'(k % 8), 1, pat[k % 8], 0);
            if (k < 8) begin
                add(1, 8'hFF, 8'hAA, one, 3'(k % 8), 1, pat[k % 8], 0);
                add(1, 8'hFF & ~one, 8'hAA, 8'h00, 3'(k % 8), 0, 0, 0);
            end
        end
        // C: ptr=7, req 81 -> 7, other changes ignored, wrap to 0
        add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h40, 8'h00, 8'h40, 3'd6, 1, 0, 0);
        add(1, 8'h00, 8'h00, 8'h00, 3'd6, 0, 0, 0);
        add(1, 8'h81, 8'hFF, 8'h80, 3'd7, 1, 1, 0);
        add(1, 8'h83, 8'hFF, 8'h80, 3'd7, 1, 1, 0);
        add(1, 8'h01, 8'hFF, 8'h00, 3'd7, 0, 0, 0);
        add(1, 8'h01, 8'hFF, 8'h01, 3'd0, 1, 1, 0);
        // D: y follows i[3] while granted to 3, y=0 when idle
        add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1, 0);
        add(1, 8'h08, 8'hF7, 8'h08, 3'd3, 1, 0, 0);
        add(1, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1, 0);
        add(1, 8'h00, 8'h08, 8'h00, 3'd3, 0, 0, 0);
        // E: reset mid-grant to 5, re-granted one cycle after reset
        add(0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h20, 8'h00, 8'h20, 3'd5, 1, 0, 0);
        add(0, 8'h20, 8'h00, 8'h00, 3'd0, 0, 0, 0);
        add(1, 8'h20, 8'h20, 8'h20, 3'd5, 1, 1, 0);
        add(1, 8'h00, 8'h00, 8'h00, 3'd5, 0, 0, 0);

        foreach (vt[k]) begin
            step(vt[k].rst_n, vt[k].req, vt[k].i);
            chk($sformatf("vec%0d_gnt", k),  gnt,          vt[k].gnt);
            chk($sformatf("vec%0d_s", k),    8'(s),        8'(vt[k].s));
            chk($sformatf("vec%0d_busy", k), 8'(busy),     8'(vt[k].busy));
            chk($sformatf("vec%0d_y", k),    8'(y),        8'(vt[k].y));
            chk($sformatf("vec%0d_to", k),   8'(timeout),  8'(vt[k].to));
        end

        // F: req=06 held with TIMEOUT_CYCLES=4
        if (TO_EN) begin
            f_gnt = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h04,
                      8'h04, 8'h04, 8'h04, 8'h00, 8'h02, 8'h02};
            f_to  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        end else begin
            for (int k = 0; k < 12; k++) begin
                f_gnt[k] = 8'h02;
                f_to[k]  = 1'b0;
            end
        end
        step(0, 8'h06, 8'h00);
        for (int k = 0; k < 12; k++) begin
            step(1, 8'h06, 8'h00);
            chk($sformatf("hold%0d_gnt", k), gnt,         f_gnt[k]);
            chk($sformatf("hold%0d_to", k),  8'(timeout), 8'(f_to[k]));
        end

        // R: randomized traffic against the model, grant order on a queue
        step(0, 8'h00, 8'h00);
        exp_q.delete();
        sb_on     = 1'b1;
        prev_busy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic       r_v;
            logic [7:0] g_exp;
            r_v = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 3) req = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) req = 8'h00;
            step(r_v, req, 8'($urandom_range(0, 255)));
            g_exp = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
            chk("rnd_gnt",  gnt,         g_exp);
            chk("rnd_s",    8'(s),       8'(m_s));
            chk("rnd_busy", 8'(busy),    8'(m_owner >= 0));
            chk("rnd_y",    8'(y),       8'((m_owner >= 0) ? i[m_s] : 1'b0));
            chk("rnd_to",   8'(timeout), 8'(m_to));
            if (busy && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_order: grant to %0d with no expected grant queued", s);
                end else begin
                    chk("sb_order", 8'(s), 8'(exp_q.pop_front()));
                end
            end
            prev_busy = busy;
        end
        chk("sb_drain", 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux81_rr_arb.md
MUX81_RR_ARB -- requirements
Module: mux81_rr_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, which sets the maximum number of consecutive cycles one requester may hold the grant (used only when MUX81_ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port req, input, 8 bits: request lines, where req[k] is requester k.
REQ-005 SHALL have port i, input, 8 bits: data inputs to the shared 8:1 mux, where i[k] belongs to requester k.
REQ-006 SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-007 SHALL have port s, output, 3 bits: select driving the mux, equal to the binary index of the set gnt bit, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a grant is active.
REQ-009 SHALL have port y, output, 1 bit: i[s] when busy is high, else 0.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement two states, IDLE and GRANT, in a registered state machine.
REQ-012 SHALL, in IDLE with req != 0, enter GRANT on the next edge, granting the lowest index k at or after ptr, scanning ptr, ptr+1, ... mod 8 with wrap 7->0.
REQ-013 SHALL, in IDLE with req == 0, stay in IDLE with gnt=0, s held, busy=0.
REQ-014 SHALL give a request-to-grant latency of exactly 1 cycle from IDLE.
REQ-015 SHALL, in GRANT, hold gnt, s and busy stable while req[owner]=1; other req changes SHALL be ignored.
REQ-016 SHALL, in GRANT with req[owner]=0, return to IDLE on the next edge, clearing gnt and busy and setting ptr=(owner+1) mod 8.
REQ-017 SHALL insert exactly one IDLE cycle between consecutive grants, with no back-to-back grant.
REQ-018 SHALL never assert more than one gnt bit, and busy SHALL equal |gnt.
REQ-019 SHALL, when the owner drops req and others rise in the same cycle, apply the release first; the new grant follows per REQ-012 using the updated ptr.
REQ-020 SHALL make y combinational from i and the registered s and busy (no added latency).

Reset
REQ-021 SHALL, on rst_n=0 at a clock edge, set state=IDLE, gnt=0, s=0, busy=0, timeout=0, ptr=0 and clear the hold counter.
REQ-022 SHALL, on reset asserted mid-grant, drop the grant on that edge; requests are re-arbitrated from ptr=0 after release.

Configuration
REQ-023 SHALL, when MUX81_ARB_TIMEOUT_EN is defined, count cycles in GRANT; when the count reaches TIMEOUT_CYCLES with req[owner] still 1, force GRANT->IDLE, pulse timeout for 1 cycle and set ptr=(owner+1) mod 8.
REQ-024 SHALL keep a forced-release owner eligible again by normal rotation.
REQ-025 SHALL, when MUX81_ARB_TIMEOUT_EN is undefined, synthesize no counter and tie timeout to 0; the port list is unchanged.

Structure
REQ-026 SHALL take the state encoding (IDLE, GRANT), N_REQ=8 and SEL_W=3 from a shared package, mux81_pkg.
REQ-027 SHALL compute y by instantiating the existing mux81_bh sub-module, with its output gated by busy.
REQ-028 SHALL implement the rotating priority pick as a pure function or combinational block inside the module, with no further sub-module.

Verification
REQ-029 SHALL cover: reset, then req=8'h01 -> cycle 1 gnt=8'h01, s=0, busy=1; drop req -> next cycle gnt=0, ptr=1.
REQ-030 SHALL cover: req=8'hFF held, each owner dropping after 2 cycles -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-031 SHALL cover: ptr=7, req=8'h81 -> gnt=8'h80; on release -> gnt=8'h01 (wrap).
REQ-032 SHALL cover: while granted to 3 with i=8'b00001000, y=1; with i=8'b11110111, y=0; and y=0 when busy=0.
REQ-033 SHALL cover: rst_n=0 during GRANT to 5 -> next cycle gnt=0, s=0; req=8'h20 still high -> granted again after 1 cycle.
REQ-034 SHALL cover: with MUX81_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, req=8'h06 held -> gnt=8'h02 for 4 cycles, timeout pulse, then gnt=8'h04; without the macro, gnt=8'h02 held indefinitely and timeout=0.
